// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencing FSM that launches the multiplier or divider and commits HI/LO
module muldiv_seq #(
  parameter int TIMEOUT = 40
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic op_i,
  input  logic mult_done_i,
  input  logic div_done_i,
  input  logic div_zero_i,
  output logic mult_start_o,
  output logic div_start_o,
  output logic hi_write_o,
  output logic lo_write_o,
  output logic sel_div_o,
  output logic busy_o,
  output logic done_o,
  output logic div0_excp_o,
  output logic timeout_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, WRITE, FIN, ERR} state_e;
  state_e state_q, state_d;
  logic op_q;
  logic cause_q;
  logic [CW-1:0] cnt_q;
  logic hit_zero, hit_done, expired;
  assign hit_zero = op_q & div_zero_i;
  assign hit_done = op_q ? div_done_i : mult_done_i;
  assign expired = cnt_q == CW'(TIMEOUT - 1);
  // State, captured op, timeout counter (saturating) and error cause
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q <= 1'b0;
      cnt_q <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= (state_q == IDLE && start_i) ? op_i : op_q;
      cnt_q <= state_q == LAUNCH ? '0 :
               (state_q == WAIT && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
      cause_q <= state_q == WAIT ? hit_zero : cause_q;
    end
  end
  // Next state: divide-by-zero beats done, and done beats the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? LAUNCH : IDLE;
      LAUNCH:  state_d = WAIT;
      WAIT:    state_d = hit_zero ? ERR : hit_done ? WRITE : expired ? ERR : WAIT;
      WRITE:   state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  // Outputs decoded purely from registered state
  always_comb begin
    busy_o = state_q != IDLE;
    sel_div_o = busy_o & op_q;
    mult_start_o = state_q == LAUNCH && !op_q;
    div_start_o = state_q == LAUNCH && op_q;
    hi_write_o = state_q == WRITE;
    lo_write_o = state_q == WRITE;
    done_o = state_q == FIN;
    div0_excp_o = state_q == ERR && cause_q;
    timeout_o = state_q == ERR && !cause_q;
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed cycle-table stimulus checked against a timeline model
module tb_muldiv_seq;
  localparam int N = 256;
  localparam int TO = 40;
  logic clk = 0, rst = 1, start = 0, op = 0, md = 0, dd = 0, dz = 0;
  logic mult_start, div_start, hi_write, lo_write, sel_div, busy, done, div0_excp, timeout;
  logic st_a[N], op_a[N], md_a[N], dd_a[N], dz_a[N], rs_a[N];
  logic [8:0] exp_v[N], dut_v[N];
  int checks = 0, passed = 0;

  muldiv_seq #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .mult_done_i(md), .div_done_i(dd), .div_zero_i(dz),
    .mult_start_o(mult_start), .div_start_o(div_start),
    .hi_write_o(hi_write), .lo_write_o(lo_write), .sel_div_o(sel_div),
    .busy_o(busy), .done_o(done), .div0_excp_o(div0_excp), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  function automatic void put(int c, logic [8:0] v);
    if (c < N) exp_v[c] = v;
  endfunction

  // Timeline model: each accepted op occupies launch, some wait cycles, then a
  // result cycle; outputs vector = {busy,sel,ms,ds,hw,lw,done,div0,timeout}.
  task automatic build_model();
    int t, c, w, n, res;
    logic o;
    for (int i = 0; i < N; i++) exp_v[i] = '0;
    t = 0;
    while (t < N) begin
      if (rs_a[t] || !st_a[t]) begin t++; continue; end
      o = op_a[t];
      c = t + 1;
      put(c, {1'b1, o, !o, o, 5'b0});
      if (c >= N || rs_a[c]) begin t = c + 1; continue; end
      n = 0; w = c + 1; res = 0;
      while (res == 0) begin
        if (w >= N) res = 4;
        else begin
          put(w, {1'b1, o, 7'b0});
          if (rs_a[w]) res = 4;
          else if (o && dz_a[w]) res = 2;
          else if (o ? dd_a[w] : md_a[w]) res = 1;
          else if (n == TO - 1) res = 3;
          else begin n++; w++; end
        end
      end
      if (res == 4) t = w + 1;
      else if (res == 1) begin
        put(w + 1, {1'b1, o, 2'b00, 2'b11, 3'b000});
        if (w + 1 < N && rs_a[w + 1]) t = w + 2;
        else begin
          put(w + 2, {1'b1, o, 4'b0000, 3'b100});
          t = w + 3;
        end
      end else begin
        put(w + 1, {1'b1, o, 5'b0, res == 2, res == 3});
        t = w + 2;
      end
    end
  endtask

  task automatic lit(int c, logic [8:0] v);
    checks++;
    if (dut_v[c] === v) passed++;
    else $display("FAIL lit cycle %0d: got %b want %b", c, dut_v[c], v);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      st_a[i] = 0; op_a[i] = 0; md_a[i] = 0; dd_a[i] = 0; dz_a[i] = 0; rs_a[i] = 0;
    end
    st_a[0] = 1; md_a[5] = 1;
    st_a[10] = 1; op_a[10] = 1; dz_a[13] = 1; dd_a[13] = 1;
    st_a[20] = 1; op_a[20] = 1; md_a[23] = 1; st_a[23] = 1; md_a[24] = 1; dd_a[26] = 1;
    st_a[30] = 1; op_a[30] = 1; rs_a[33] = 1; dd_a[34] = 1; dd_a[35] = 1;
    for (int i = 40; i <= 47; i++) st_a[i] = 1;
    op_a[46] = 1; op_a[47] = 1; md_a[43] = 1; dd_a[49] = 1;
    st_a[55] = 1; md_a[57] = 1;
    st_a[65] = 1; dd_a[70] = 1; dz_a[70] = 1;
    st_a[110] = 1; op_a[110] = 1; md_a[130] = 1; dd_a[151] = 1;
    st_a[160] = 1; op_a[160] = 1; dz_a[201] = 1;
    st_a[205] = 1; op_a[205] = 1;
    build_model();
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < N; cyc++) begin
      @(posedge clk);
      #1;
      rst = rs_a[cyc]; start = st_a[cyc]; op = op_a[cyc];
      md = md_a[cyc]; dd = dd_a[cyc]; dz = dz_a[cyc];
      @(negedge clk);
      dut_v[cyc] = {busy, sel_div, mult_start, div_start, hi_write, lo_write, done, div0_excp, timeout};
      checks++;
      if (dut_v[cyc] === exp_v[cyc]) passed++;
      else $display("FAIL cycle %0d outputs: got %b want %b", cyc, dut_v[cyc], exp_v[cyc]);
    end
    lit(0, 9'b0);
    lit(1, 9'b1_0_10_00_000);
    lit(6, 9'b1_0_00_11_000);
    lit(7, 9'b1_0_00_00_100);
    lit(8, 9'b0);
    lit(14, 9'b1_1_00_00_010);
    lit(15, 9'b0);
    lit(21, 9'b1_1_01_00_000);
    lit(27, 9'b1_1_00_11_000);
    lit(34, 9'b0);
    lit(36, 9'b0);
    lit(45, 9'b1_0_00_00_100);
    lit(47, 9'b1_1_01_00_000);
    lit(51, 9'b1_1_00_00_100);
    lit(59, 9'b1_0_00_00_100);
    lit(106, 9'b1_0_00_00_000);
    lit(107, 9'b1_0_00_00_001);
    lit(108, 9'b0);
    lit(153, 9'b1_1_00_00_100);
    lit(202, 9'b1_1_00_00_010);
    lit(247, 9'b1_1_00_00_001);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter TIMEOUT, default 40: maximum WAIT cycles allowed before a unit is declared hung.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  operation request from the control unit, sampled only in IDLE.
REQ-005 op  input  1  operation select: 0 = mult, 1 = div; sampled with start.
REQ-006 mult_done  input  1  multiplier completion flag.
REQ-007 div_done  input  1  divider completion flag.
REQ-008 div_zero  input  1  divider divide-by-zero flag.
REQ-009 mult_start  output  1  one-cycle start pulse to the multiplier.
REQ-010 div_start  output  1  one-cycle start pulse to the divider.
REQ-011 hi_write  output  1  HI register write enable.
REQ-012 lo_write  output  1  LO register write enable.
REQ-013 sel_div  output  1  HI/LO input mux select: 0 = multiplier, 1 = divider.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle successful-completion pulse.
REQ-016 div0_excp  output  1  one-cycle divide-by-zero exception pulse.
REQ-017 timeout  output  1  one-cycle hung-unit exception pulse.

Function
REQ-018 The FSM SHALL have exactly six states: IDLE, LAUNCH, WAIT, WRITE, FIN, ERR.
REQ-019 IDLE: start=1 SHALL capture op into op_r and move to LAUNCH; start=0 SHALL hold IDLE.
REQ-020 LAUNCH: the FSM SHALL assert mult_start (op_r=0) or div_start (op_r=1) for exactly one cycle, clear the cycle counter to 0 and move to WAIT.
REQ-021 WAIT: the counter SHALL increment by 1 per cycle; its width SHALL be clog2(TIMEOUT+1) bits, and it SHALL never wrap.
REQ-022 WAIT, op_r=0: mult_done=1 SHALL move to WRITE; div_done and div_zero SHALL be ignored.
REQ-023 WAIT, op_r=1: div_zero=1 SHALL move to ERR with cause div0; otherwise div_done=1 SHALL move to WRITE; mult_done SHALL be ignored.
REQ-024 WAIT: div_zero and div_done high in the same cycle SHALL resolve as div0 (exception wins).
REQ-025 WAIT: if the counter equals TIMEOUT-1 and no qualifying done/zero is seen, the FSM SHALL move to ERR with cause timeout; a done arriving in that same cycle SHALL win.
REQ-026 WRITE: hi_write and lo_write SHALL both be 1 for exactly one cycle, then the FSM SHALL move to FIN.
REQ-027 FIN: done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-028 ERR: div0_excp or timeout (per cause) SHALL be 1 for one cycle, then the FSM SHALL return to IDLE; hi_write and lo_write SHALL remain 0.
REQ-029 sel_div SHALL equal op_r from LAUNCH through FIN and SHALL be 0 in IDLE.
REQ-030 start asserted while busy=1 SHALL be ignored (no queuing); op changes while busy SHALL not affect op_r.
REQ-031 Latency: with start at cycle 0 and the unit done sampled at cycle k≥2, write SHALL occur at k+1 and done at k+2; the minimum start-to-done latency is 4 cycles.
REQ-032 A new start SHALL be accepted in the cycle after done, div0_excp or timeout (back-to-back operation).
REQ-033 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.

Reset
REQ-034 reset=1 at an edge SHALL force IDLE, op_r=0 and counter=0, and drive all outputs to 0 after that edge.
REQ-035 reset SHALL take priority over every transition, including one mid-operation (any state).
REQ-036 Unit done/zero flags arriving after a reset SHALL be ignored until a new LAUNCH.

Verification
REQ-037 Mult path: reset, then start=1, op=0 at cycle 0, mult_done at cycle 5 -> mult_start at cycle 1; hi_write=lo_write=1 and sel_div=0 at cycle 6; done at cycle 7; busy low at cycle 8.
REQ-038 Div by zero: start with op=1, then div_zero and div_done both high at cycle 3 -> div0_excp at cycle 4; no hi_write or lo_write; IDLE at cycle 5.
REQ-039 Timeout: TIMEOUT=40, op=0, mult_done never asserted -> timeout pulse exactly 40 WAIT cycles after LAUNCH; no write; no done.
REQ-040 Ignored inputs: op=1 run with spurious mult_done in WAIT and a second start at cycle 3 -> no transition on either; single div_start; final result sel_div=1.
REQ-041 Reset mid-WAIT, then div_done one cycle later -> all outputs 0; no hi_write or done; FSM stays IDLE.
REQ-042 Back-to-back: start held high continuously with op=0 then op=1 -> second operation launches the cycle after the first done; sel_div switches 0 to 1.
